// File: rtl/greycode_stream_codec_pkg.sv
// rtl/greycode_stream_codec_pkg.sv - shared mode encoding and lane-slice helper for the Gray stream codec
package greycode_pkg;

  localparam logic MODE_G2B = 1'b0;
  localparam logic MODE_B2G = 1'b1;

  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/greycode_stream_codec_if.sv
// rtl/greycode_stream_codec_if.sv - beat stream, error and clear signals of the Gray stream codec
interface greycode_stream_codec_if #(
  parameter int WIDTH     = 8,
  parameter int NUM_LANES = 4
);
  logic                       in_valid;
  logic                       in_ready;
  logic                       in_mode;
  logic [NUM_LANES*WIDTH-1:0] in_data;
  logic                       out_valid;
  logic                       out_ready;
  logic                       out_mode;
  logic [NUM_LANES*WIDTH-1:0] out_data;
  logic [NUM_LANES-1:0]       out_err;
  logic [NUM_LANES-1:0]       err_sticky;
  logic                       clr_err;

  modport master (
    output in_valid, in_mode, in_data, out_ready, clr_err,
    input  in_ready, out_valid, out_mode, out_data, out_err, err_sticky
  );

  modport slave (
    input  in_valid, in_mode, in_data, out_ready, clr_err,
    output in_ready, out_valid, out_mode, out_data, out_err, err_sticky
  );
endinterface

// File: rtl/greycode_stream_codec_lane_conv.sv
// rtl/greycode_stream_codec_lane_conv.sv - combinational Gray<->binary conversion of one lane word
module greycode_lane_conv
  import greycode_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             mode_i,
  input  logic [WIDTH-1:0] word_i,
  output logic [WIDTH-1:0] word_o
);

  logic [WIDTH-1:0] bin_w;

  // Decode is a prefix XOR from the MSB down; each bit depends on the one above it.
  always_comb begin
    bin_w = '0;
    bin_w[WIDTH-1] = word_i[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      bin_w[i] = word_i[i] ^ bin_w[i+1];
    end
  end

  assign word_o = (mode_i == MODE_B2G) ? (word_i ^ (word_i >> 1)) : bin_w;

endmodule

// File: rtl/greycode_stream_codec.sv
// rtl/greycode_stream_codec.sv - multi-lane pipelined Gray/binary codec with per-lane step check
module greycode_stream_codec
  import greycode_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_LANES = 4,
  parameter int LATENCY   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  greycode_stream_codec_if.slave  bus
);

  if (LATENCY < 1) begin : g_latency_check
    $error("greycode_stream_codec: LATENCY must be >= 1");
  end

  localparam int DW = NUM_LANES * WIDTH;

  logic                 adv;
  logic                 accept;
  logic                 emit;
  logic [DW-1:0]        conv_data;
  logic [NUM_LANES-1:0] err_in;

  logic [WIDTH-1:0]     hist_q [NUM_LANES];
  logic [WIDTH-1:0]     hist_d [NUM_LANES];
  logic [NUM_LANES-1:0] hist_valid_q, hist_valid_d;
  logic [NUM_LANES-1:0] sticky_q, sticky_d;

  logic                 st_valid_q [LATENCY];
  logic                 st_mode_q  [LATENCY];
  logic [DW-1:0]        st_data_q  [LATENCY];
  logic [NUM_LANES-1:0] st_err_q   [LATENCY];

  assign adv    = bus.out_ready || !bus.out_valid;
  assign accept = bus.in_valid && adv;
  assign emit   = bus.out_valid && bus.out_ready;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    greycode_lane_conv #(.WIDTH(WIDTH)) u_conv (
      .mode_i (bus.in_mode),
      .word_i (bus.in_data[lane_lsb(k, WIDTH) +: WIDTH]),
      .word_o (conv_data[lane_lsb(k, WIDTH) +: WIDTH])
    );
  end

  // More than one bit flipping since the last decoded word is a step violation.
  always_comb begin
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] diff;
    err_in       = '0;
    hist_d       = hist_q;
    hist_valid_d = hist_valid_q;
    for (int k = 0; k < NUM_LANES; k++) begin
      word = bus.in_data[lane_lsb(k, WIDTH) +: WIDTH];
      diff = word ^ hist_q[k];
      if (bus.in_mode == MODE_G2B) begin
        err_in[k] = hist_valid_q[k] && ((diff & (diff - WIDTH'(1))) != '0);
        if (accept) begin
          hist_d[k]       = word;
          hist_valid_d[k] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sticky_d = sticky_q;
    if (bus.clr_err) sticky_d = '0;
    if (emit) sticky_d = sticky_d | st_err_q[LATENCY-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_valid_q <= '0;
      sticky_q     <= '0;
      for (int k = 0; k < NUM_LANES; k++) hist_q[k] <= '0;
    end else begin
      hist_valid_q <= hist_valid_d;
      sticky_q     <= sticky_d;
      hist_q       <= hist_d;
    end
  end

  // Single global enable: all stages shift together or all hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        st_valid_q[i] <= 1'b0;
        st_mode_q[i]  <= 1'b0;
        st_data_q[i]  <= '0;
        st_err_q[i]   <= '0;
      end
    end else if (adv) begin
      st_valid_q[0] <= bus.in_valid;
      st_mode_q[0]  <= bus.in_mode;
      st_data_q[0]  <= conv_data;
      st_err_q[0]   <= bus.in_valid ? err_in : '0;
      for (int i = LATENCY - 1; i > 0; i--) begin
        st_valid_q[i] <= st_valid_q[i-1];
        st_mode_q[i]  <= st_mode_q[i-1];
        st_data_q[i]  <= st_data_q[i-1];
        st_err_q[i]   <= st_err_q[i-1];
      end
    end
  end

  assign bus.in_ready   = adv;
  assign bus.out_valid  = st_valid_q[LATENCY-1];
  assign bus.out_mode   = st_mode_q[LATENCY-1];
  assign bus.out_data   = st_data_q[LATENCY-1];
  assign bus.out_err    = st_err_q[LATENCY-1];
  assign bus.err_sticky = sticky_q;

endmodule

// File: tb/tb_greycode_stream_codec.sv
// tb/tb_greycode_stream_codec.sv - self-checking bench for greycode_stream_codec
module tb_greycode_stream_codec;

  localparam int W   = 8;
  localparam int NL  = 4;
  localparam int LAT = 2;
  localparam int DW  = W * NL;

  typedef struct {
    logic          mode;
    logic [DW-1:0] data;
    logic [NL-1:0] err;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;

  greycode_stream_codec_if #(.WIDTH(W), .NUM_LANES(NL)) bus ();

  greycode_stream_codec #(.WIDTH(W), .NUM_LANES(NL), .LATENCY(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_emit = 0;

  beat_t         exp_q[$];
  logic [W-1:0]  m_hist [NL];
  logic [NL-1:0] m_hval;
  logic [NL-1:0] m_sticky;
  logic          prev_stall;
  logic [DW-1:0] prev_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic beat_t model_beat(input logic mode, input logic [DW-1:0] din);
    beat_t b;
    b.mode = mode;
    b.data = '0;
    b.err  = '0;
    for (int k = 0; k < NL; k++) begin
      logic [W-1:0] w, r;
      w = din[k*W +: W];
      r = '0;
      if (mode == 1'b0) begin
        for (int s = 0; s < W; s++) r = r ^ (w >> s);
        b.err[k] = m_hval[k] && ($countones(w ^ m_hist[k]) > 1);
        m_hist[k] = w;
        m_hval[k] = 1'b1;
      end else begin
        r = w ^ (w >> 1);
      end
      b.data[k*W +: W] = r;
    end
    return b;
  endfunction

  // Per-cycle compare at the falling edge; handshakes seen here take effect at the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_hval     = '0;
      m_sticky   = '0;
      prev_stall = 1'b0;
      for (int k = 0; k < NL; k++) m_hist[k] = '0;
    end else begin
      logic emit, acc;
      emit = bus.out_valid && bus.out_ready;
      acc  = bus.in_valid && bus.in_ready;
      chk("in_ready_rule", bus.in_ready, bus.out_ready || !bus.out_valid);
      chk("err_sticky", bus.err_sticky, m_sticky);
      if (prev_stall) begin
        chk("hold_valid", bus.out_valid, 1'b1);
        chk("hold_data", bus.out_data, prev_data);
      end
      if (bus.out_valid && !bus.out_ready) chk("in_ready_stall", bus.in_ready, 1'b0);
      if (emit) begin
        n_emit++;
        if (exp_q.size() == 0) begin
          chk("spurious_beat", 1'b1, 1'b0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("out_data", bus.out_data, e.data);
          chk("out_mode", bus.out_mode, e.mode);
          chk("out_err", bus.out_err, e.err);
          m_sticky = (bus.clr_err ? '0 : m_sticky) | e.err;
        end
      end else if (bus.clr_err) begin
        m_sticky = '0;
      end
      if (acc) exp_q.push_back(model_beat(bus.in_mode, bus.in_data));
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end
  end

  task automatic send(input logic mode, input logic [DW-1:0] d);
    logic ok;
    ok = 1'b0;
    bus.in_mode  = mode;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output logic [DW-1:0] d, output logic [NL-1:0] e,
                          output logic m, output int lat);
    logic found;
    found = 1'b0;
    lat = 0;
    d = '0;
    e = '0;
    m = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) begin
        found = 1'b1;
        d = bus.out_data;
        e = bus.out_err;
        m = bus.out_mode;
        break;
      end
    end
    if (!found) chk("wait_out_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] d;
    logic [NL-1:0] e;
    logic          m;
    int            lat;
    int            base;
    logic [7:0]    step_v [4];
    logic [NL-1:0] step_e [4];

    step_v = '{8'h00, 8'h01, 8'h03, 8'h00};
    step_e = '{4'b0000, 4'b0000, 4'b0000, 4'b0001};

    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_mode = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    bus.clr_err = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data", bus.out_data, '0);
    chk("rst_out_mode", bus.out_mode, 1'b0);
    chk("rst_out_err", bus.out_err, '0);
    chk("rst_err_sticky", bus.err_sticky, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    send(1'b0, 32'h00FF0CC0);
    wait_out(d, e, m, lat);
    chk("dec_data", d, 32'h00AA0880);
    chk("dec_err", e, 4'b0000);
    chk("dec_mode", m, 1'b0);
    chk("dec_latency", lat, 2);

    send(1'b1, 32'h05AA0880);
    wait_out(d, e, m, lat);
    chk("enc_data", d, 32'h07FF0CC0);
    chk("enc_mode", m, 1'b1);
    chk("enc_err", e, 4'b0000);
    send(1'b0, 32'h00FF0CC0);
    wait_out(d, e, m, lat);
    chk("enc_hist_untouched", e, 4'b0000);

    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(1'b0, {24'h0, step_v[i]});
      wait_out(d, e, m, lat);
      chk($sformatf("step_err_%0d", i), e, step_e[i]);
    end
    @(negedge clk);
    chk("step_sticky_set", bus.err_sticky, 4'b0001);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send(1'b0, 32'h0000000F);
    wait_out(d, e, m, lat);
    chk("clr_beat_err", e, 4'b0001);
    bus.clr_err = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.clr_err = 1'b0;
    @(negedge clk);
    chk("clr_vs_set", bus.err_sticky, 4'b0001);
    @(posedge clk);
    #1;
    bus.clr_err = 1'b1;
    @(posedge clk);
    #1;
    bus.clr_err = 1'b0;
    @(negedge clk);
    chk("clr_alone", bus.err_sticky, 4'b0000);
    @(posedge clk);
    #1;

    do_reset();
    base = n_emit;
    fork
      begin
        for (int i = 0; i < 8; i++) send(i[0], 32'h1357_9BDF ^ (32'h0101_0101 * i));
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
    chk("bp_count", n_emit - base, 8);
    chk("bp_drained", exp_q.size(), 0);
    @(posedge clk);
    #1;

    do_reset();
    send(1'b0, 32'h00000000);
    wait_out(d, e, m, lat);
    chk("mix_err_0", e, 4'b0000);
    send(1'b1, 32'h000000FF);
    wait_out(d, e, m, lat);
    chk("mix_err_1", e, 4'b0000);
    chk("mix_enc_data", d, 32'h00000080);
    send(1'b0, 32'h00000001);
    wait_out(d, e, m, lat);
    chk("mix_err_2", e, 4'b0000);
    chk("mix_dec_data", d, 32'h00000001);
    send(1'b1, 32'h000000FF);
    wait_out(d, e, m, lat);
    chk("mix_err_3", e, 4'b0000);

    do_reset();
    send(1'b0, 32'h11111111);
    send(1'b0, 32'h22222222);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", bus.out_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_idle", bus.out_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    send(1'b0, 32'hFFFFFFFF);
    wait_out(d, e, m, lat);
    chk("midrst_err", e, 4'b0000);
    chk("midrst_data", d, 32'hAAAAAAAA);
    repeat (3) @(negedge clk);
    chk("final_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
